spi_cmd_decoder: RTL and testbench

//  Consumes the byte stream from the SPI bridge (byte_sync/data_in) and turns 2-byte SPI frames into

---
 rtl/spi_cmd_decoder.sv | 162 ++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns 2-byte SPI frames (command + data/dummy) received from
// the SPI bridge into one-cycle read/write strobes for the PWM register bank,
// and returns read data to the bridge through data_out.
module spi_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_sync,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [5:0] addr,
  output logic       read,
  output logic       write,
  output logic [7:0] data_write,
  input  logic [7:0] data_read,
  output logic       cmd_err
);

  // A zero timeout disables the counter, but it still needs a legal width.
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // The counter is compared against its last pre-limit value, so the timeout
  // fires on the very edge where it would become TIMEOUT_CYCLES; it never wraps.
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned LAT_W   = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DATA  = 2'd1,
    READ_FETCH = 2'd2,
    WAIT_DUMMY = 2'd3
  } state_e;

  state_e            state, state_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
  logic              dummy_seen, dummy_seen_d;
  logic [5:0]        addr_d;
  logic [7:0]        data_write_d;
  logic [7:0]        data_out_d;
  logic              read_d, write_d, cmd_err_d;
  logic              timeout_hit;
  logic              capture;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TO_LAST));
  assign capture     = (lat_cnt == LAT_W'(READ_LATENCY - 1));

  // State register and all registered outputs; reset returns everything to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      to_cnt     <= '0;
      lat_cnt    <= '0;
      dummy_seen <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      data_out   <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would chain updates within one edge.
      state      <= state_d;
      to_cnt     <= to_cnt_d;
      lat_cnt    <= lat_cnt_d;
      dummy_seen <= dummy_seen_d;
      addr       <= addr_d;
      data_write <= data_write_d;
      data_out   <= data_out_d;
      read       <= read_d;
      write      <= write_d;
      cmd_err    <= cmd_err_d;
    end
  end

  // Frame decoding: next state, counters and next values of the outputs.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred; holds are explicit copies.
    state_d      = state;
    to_cnt_d     = to_cnt;
    lat_cnt_d    = lat_cnt;
    dummy_seen_d = dummy_seen;
    addr_d       = addr;
    data_write_d = data_write;
    data_out_d   = data_out;
    read_d       = 1'b0;
    write_d      = 1'b0;
    cmd_err_d    = 1'b0;

    case (state)
      IDLE: begin
        if (byte_sync) begin
          if (data_in[6]) begin
            // Reserved bit set: flag and drop the byte.
            cmd_err_d = 1'b1;
          end else begin
            addr_d = data_in[5:0];
            if (data_in[7]) begin
              state_d  = WAIT_DATA;
              to_cnt_d = '0;
            end else begin
              read_d       = 1'b1;
              state_d      = READ_FETCH;
              lat_cnt_d    = '0;
              dummy_seen_d = 1'b0;
            end
          end
        end
      end

      READ_FETCH: begin
        if (capture) begin
          data_out_d = data_read;
          // A dummy byte that arrived during the fetch already closes the frame.
          if (dummy_seen || byte_sync) begin
            state_d = IDLE;
          end else begin
            state_d  = WAIT_DUMMY;
            to_cnt_d = '0;
          end
        end else begin
          lat_cnt_d = lat_cnt + LAT_W'(1);
          if (byte_sync) begin
            dummy_seen_d = 1'b1;
          end
        end
      end

      WAIT_DATA: begin
        if (byte_sync) begin
          data_write_d = data_in;
          write_d      = 1'b1;
          state_d      = IDLE;
        end else if (timeout_hit) begin
          cmd_err_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          to_cnt_d = to_cnt + TO_W'(1);
        end
      end

      WAIT_DUMMY: begin
        if (byte_sync) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          cmd_err_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          to_cnt_d = to_cnt + TO_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Testbench for spi_cmd_decoder: directed frames plus a random byte stream.
// A frame-level reference model predicts strobe events into a queue; a
// separate monitor pops and compares whenever the DUT raises a strobe.
module tb_spi_cmd_decoder;

  localparam int TO = 16;
  localparam int RL = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [5:0] addr;
  logic       read;
  logic       write;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic       cmd_err;

  spi_cmd_decoder #(.TIMEOUT_CYCLES(TO), .READ_LATENCY(RL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .addr       (addr),
    .read       (read),
    .write      (write),
    .data_write (data_write),
    .data_read  (data_read),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank model: fixed contents; the correct byte is presented only
  // in the cycle the decoder must sample it, its complement otherwise.
  logic [7:0] bank [64];
  int rd_age = 15;
  always @(posedge clk) begin
    if (read) rd_age <= 1;
    else if (rd_age < 15) rd_age <= rd_age + 1;
  end
  assign data_read = (((read ? 0 : rd_age)) == RL - 1) ? bank[addr] : ~bank[addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {EV_WR, EV_RD, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         cyc;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] prev;
  } ev_t;
  ev_t exp_q[$];

  typedef enum int {M_CMD, M_DATA, M_READ} mmode_e;
  mmode_e     m_mode = M_CMD;
  int         m_tcmd = 0;
  logic [5:0] m_addr = '0;
  logic [7:0] m_dout = '0;

  task automatic push_ev(input ev_kind_e k, input int c, input logic [5:0] a,
                         input logic [7:0] d, input logic [7:0] p);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.data = d; e.prev = p;
    exp_q.push_back(e);
  endtask

  // Resolve frame timeouts up to cycle t. A write frame accepts its data
  // byte in cycles T+1..T+TO; a read frame accepts its dummy up to T+RL+TO.
  task automatic model_advance(input int t);
    if (m_mode == M_DATA && t >= m_tcmd + TO + 1) begin
      push_ev(EV_ERR, m_tcmd + TO + 1, '0, '0, '0);
      m_mode = M_CMD;
    end
    if (m_mode == M_READ && t >= m_tcmd + RL + TO + 1) begin
      push_ev(EV_ERR, m_tcmd + RL + TO + 1, '0, '0, '0);
      m_mode = M_CMD;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int t);
    case (m_mode)
      M_CMD: begin
        if (b[6]) begin
          push_ev(EV_ERR, t + 1, '0, '0, '0);
        end else if (b[7]) begin
          m_mode = M_DATA; m_tcmd = t; m_addr = b[5:0];
        end else begin
          m_addr = b[5:0];
          push_ev(EV_RD, t + 1, m_addr, bank[m_addr], m_dout);
          m_dout = bank[m_addr];
          m_mode = M_READ; m_tcmd = t;
        end
      end
      M_DATA: begin
        push_ev(EV_WR, t + 1, m_addr, b, '0);
        m_mode = M_CMD;
      end
      default: m_mode = M_CMD;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit has_b, input logic [7:0] b);
    @(posedge clk); #2;
    model_advance(cyc);
    if (has_b) begin
      model_byte(b, cyc);
      data_in = b;
    end
    byte_sync = has_b;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"},   data_out,   0);
    check({tag, "_addr"},       addr,       0);
    check({tag, "_data_write"}, data_write, 0);
    check({tag, "_read"},       read,       0);
    check({tag, "_write"},      write,      0);
    check({tag, "_cmd_err"},    cmd_err,    0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [7:0] mon_dout;
    bit         pend;
    int         pend_cyc;
    logic [7:0] pend_prev, pend_val;
    ev_t        e;
    ev_kind_e   act_kind;
    mon_dout = '0; pend = 0; pend_cyc = 0; pend_prev = '0; pend_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_dout = '0;
        pend = 0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          n_checks++; n_errors++;
          $display("FAIL missed_event: kind %0d expected at cycle %0d, no strobe by cycle %0d",
                   int'(e.kind), e.cyc, cyc);
        end
        if (pend && cyc == pend_cyc - 1) check("dout_before_capture", data_out, pend_prev);
        if (pend && cyc == pend_cyc) begin
          check("dout_capture", data_out, pend_val);
          mon_dout = pend_val;
          pend = 0;
        end
        if (read || write || cmd_err) begin
          check("rd_wr_exclusive", read & write, 0);
          act_kind = read ? EV_RD : (write ? EV_WR : EV_ERR);
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_strobe: kind %0d at cycle %0d, none expected",
                     int'(act_kind), cyc);
          end else begin
            e = exp_q.pop_front();
            check("event_kind",  int'(act_kind), int'(e.kind));
            check("event_cycle", cyc, e.cyc);
            check("dout_hold",   data_out, mon_dout);
            if (e.kind == EV_WR) begin
              check("wr_addr", addr, e.addr);
              check("wr_data", data_write, e.data);
            end else if (e.kind == EV_RD) begin
              check("rd_addr", addr, e.addr);
              pend = 1; pend_cyc = cyc + RL; pend_prev = e.prev; pend_val = e.data;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    logic [7:0] b;
    rst_n = 1'b0; byte_sync = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 64; i++) bank[i] = 8'($urandom);
    bank[6'h12] = 8'h3C;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #2; rst_n = 1'b1;
    idle(2);

    // 1: plain write
    send(8'h85); idle(1); send(8'hA5); idle(3);
    // 2: read of 0x12, bank returns 0x3C
    send(8'h12); send(8'h00); idle(4);
    check("t2_dout_after_dummy", data_out, 8'h3C);
    // 3: reserved bit, then a clean write
    send(8'h45); idle(2); send(8'h81); idle(1); send(8'h7F); idle(3);
    // 4: write timeout, then 0x22 is a read command
    send(8'h83); idle(TO); send(8'h22); send(8'h00); idle(3);
    // timeout boundary: last accepted data cycle, then the first rejected one
    send(8'h8A); idle(TO - 1); send(8'h5A); idle(2);
    send(8'h8B); idle(TO);     send(8'h21); idle(1); send(8'h00); idle(2);
    // read frame whose dummy never comes
    send(8'h10); idle(TO + RL + 3);

    // 5: reset between command and data byte
    send(8'h84); idle(2);
    @(posedge clk); #2;
    model_advance(cyc);
    rst_n = 1'b0; byte_sync = 1'b0;
    m_mode = M_CMD; m_dout = '0; exp_q.delete();
    #1; check_all_zero("midreset");
    @(posedge clk); #2; rst_n = 1'b1;
    idle(1);
    send(8'h55); idle(2); send(8'h81); idle(1); send(8'h33); idle(3);

    // 6: back-to-back frames with minimal spacing
    send(8'h81); send(8'h11); send(8'h02); send(8'h00); idle(3);

    // random byte stream with gaps clustered around the timeout limit
    for (int n = 0; n < 400; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 9) != 0) b[6] = 1'b0;
      send(b);
      if ($urandom_range(0, 14) == 0) gap = TO - 2 + int'($urandom_range(0, 3));
      else gap = int'($urandom_range(0, 3));
      idle(gap);
    end

    idle(TO + RL + 6);
    check("queue_drained", exp_q.size(), 0);
    check("final_data_out", data_out, m_dout);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
